// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard
//
// Issue-side interlock for the 5-stage pipeline. A three-slot shadow pipeline
// (EX, MEM, WB) follows every issued instruction until it leaves WB. A
// one-cycle stall plus bubble is raised when the ID instruction reads the
// destination of a load sitting in EX, the only hazard forwarding cannot
// resolve. Per-register pending counters and a saturating stall counter are
// exported for debug.
//
// Ports:
//   Clk                      pipeline clock, rising edge
//   Reset                    synchronous, active-high; clears all state
//   ID_Valid                 IF/ID holds a real instruction
//   ID_RegRs, ID_RegRt       source register numbers of the ID instruction
//   ID_UsesRs, ID_UsesRt     the ID instruction really reads that source
//   ID_RegRd                 destination register (already muxed)
//   ID_RegWrite, ID_MemRead  control outputs for the ID instruction
//   Flush                    kill the ID instruction (taken branch/jump)
//   Stall                    hold PC and IF/ID
//   Bubble                   zero ID/EX control fields this cycle
//   Pending                  bit r set while an in-flight instruction will write r
//   Stall_Count              stall cycles since reset, saturating

module load_use_scoreboard #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   ID_Valid,
    input  logic [4:0]             ID_RegRs,
    input  logic [4:0]             ID_RegRt,
    input  logic                   ID_UsesRs,
    input  logic                   ID_UsesRt,
    input  logic [4:0]             ID_RegRd,
    input  logic                   ID_RegWrite,
    input  logic                   ID_MemRead,
    input  logic                   Flush,
    output logic                   Stall,
    output logic                   Bubble,
    output logic [31:0]            Pending,
    output logic [STALL_CNT_W-1:0] Stall_Count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } slot_t;

    slot_t ex_q, ex_d, mem_q, wb_q;

    // One 2-bit counter per register; at most one writer per slot, so <= 3.
    logic [31:0][1:0] cnt_q, cnt_d;

    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic ex_writer, wb_writer, issue, issue_writer, hit_rs, hit_rt;

    assign ex_writer = ex_q.valid & ex_q.regwrite & (ex_q.rd != 5'd0);
    assign wb_writer = wb_q.valid & wb_q.regwrite & (wb_q.rd != 5'd0);

    assign hit_rs = ID_UsesRs & (ID_RegRs == ex_q.rd);
    assign hit_rt = ID_UsesRt & (ID_RegRt == ex_q.rd);

    // Flush wins over the interlock: a killed instruction never stalls.
    assign Stall  = ID_Valid & ex_writer & ex_q.memread & (hit_rs | hit_rt) & ~Flush;
    assign Bubble = Stall;

    assign issue        = ID_Valid & ~Stall & ~Flush;
    assign issue_writer = issue & ID_RegWrite & (ID_RegRd != 5'd0);

    always_comb begin
        ex_d = '0;
        if (issue) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = ID_RegRd;
            ex_d.regwrite = ID_RegWrite;
            ex_d.memread  = ID_MemRead;
        end
    end

    always_comb begin
        logic inc, dec;
        cnt_d = cnt_q;
        for (int unsigned r = 1; r < 32; r++) begin
            inc = issue_writer & (ID_RegRd == 5'(r));
            dec = wb_writer & (wb_q.rd == 5'(r));
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + 2'd1;
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - 2'd1;
            end
        end
        cnt_d[0] = 2'd0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        Pending = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            Pending[r] = (cnt_q[r] != 2'd0);
        end
    end

    assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Bench for load_use_scoreboard. A timestamped log of issued writers serves
// as the reference: an entry issued on edge e is pending for the three cycles
// after e and is "a load in EX" only in the first of them.

module tb_load_use_scoreboard;

    localparam int unsigned SmallW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, uses_rs, uses_rt, regwrite, memread, flush;
    logic [4:0]  rs, rt, rd;
    logic        stall, bubble, stall_s, bubble_s;
    logic [31:0] pending, pending_s;
    logic [15:0] stall_cnt;
    logic [SmallW-1:0] stall_cnt_s;

    always #5 clk = ~clk;

    load_use_scoreboard #(.STALL_CNT_W(16)) dut (
        .Clk(clk), .Reset(rst), .ID_Valid(id_valid), .ID_RegRs(rs), .ID_RegRt(rt),
        .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt), .ID_RegRd(rd), .ID_RegWrite(regwrite),
        .ID_MemRead(memread), .Flush(flush), .Stall(stall), .Bubble(bubble),
        .Pending(pending), .Stall_Count(stall_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    load_use_scoreboard #(.STALL_CNT_W(SmallW)) dut_small (
        .Clk(clk), .Reset(rst), .ID_Valid(id_valid), .ID_RegRs(rs), .ID_RegRt(rt),
        .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt), .ID_RegRd(rd), .ID_RegWrite(regwrite),
        .ID_MemRead(memread), .Flush(flush), .Stall(stall_s), .Bubble(bubble_s),
        .Pending(pending_s), .Stall_Count(stall_cnt_s)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned e;
        logic [4:0]  rd;
        bit          load;
    } wr_t;

    wr_t         inflight[$];
    int unsigned cyc = 0;
    int unsigned m_cnt = 0;
    int unsigned m_cnt_s = 0;
    bit          m_s;
    wr_t         m_w;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic bit m_stall();
        bit s = 1'b0;
        if (!id_valid || flush) return 1'b0;
        foreach (inflight[i]) begin
            if (cyc - inflight[i].e == 1 && inflight[i].load &&
                ((uses_rs && rs == inflight[i].rd) || (uses_rt && rt == inflight[i].rd)))
                s = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p = '0;
        foreach (inflight[i]) begin
            if (cyc - inflight[i].e >= 1 && cyc - inflight[i].e <= 3) p[inflight[i].rd] = 1'b1;
        end
        return p;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            inflight.delete();
            m_cnt   = 0;
            m_cnt_s = 0;
        end else begin
            m_s = m_stall();
            if (m_s) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_s < (1 << SmallW) - 1) m_cnt_s++;
            end
            if (id_valid && !m_s && !flush && regwrite && rd != 5'd0) begin
                m_w.e    = cyc;
                m_w.rd   = rd;
                m_w.load = memread;
                inflight.push_back(m_w);
            end
        end
        cyc++;
        while (inflight.size() > 0 && cyc - inflight[0].e > 3) void'(inflight.pop_front());
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_id(input logic v, input logic [4:0] a, input logic ua,
                          input logic [4:0] b, input logic ub, input logic [4:0] d,
                          input logic w, input logic m, input logic f);
        id_valid = v; rs = a; uses_rs = ua; rt = b; uses_rt = ub;
        rd = d; regwrite = w; memread = m; flush = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_id(1, 0, 0, 0, 0, 3, 1, 1, 0);
        step();
        step();
        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (pending !== 32'h0) begin
            n_fail++; $display("FAIL reset_pending: got %h expected %h", pending, 32'h0);
        end
        n_checks++;
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b/%b expected 0/0", stall, bubble);
        end
        n_checks++;
        if (stall_cnt !== 16'h0 || stall_cnt_s !== '0) begin
            n_fail++; $display("FAIL reset_count: got %h/%h expected 0", stall_cnt, stall_cnt_s);
        end
        step();
    endtask

    task automatic test_alu_writer();
        drain();
        set_id(1, 2, 1, 3, 1, 1, 1, 0, 0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (pending !== ((k <= 3) ? 32'h2 : 32'h0) || pending !== m_pending()) begin
                n_fail++;
                $display("FAIL alu_pending cyc%0d: got %h expected %h", k, pending, m_pending());
            end
            n_checks++;
            if (stall !== 1'b0) begin
                n_fail++; $display("FAIL alu_stall cyc%0d: got %b expected 0", k, stall);
            end
            step();
        end
    endtask

    task automatic test_load_use();
        int unsigned c0;
        drain();
        c0 = m_cnt;
        set_id(1, 1, 1, 0, 0, 5, 1, 1, 0);       // lw r5
        step();
        set_id(1, 5, 1, 7, 1, 6, 1, 0, 0);       // add r6,r5,r7
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1 || bubble !== 1'b1) begin
            n_fail++; $display("FAIL loaduse_stall: got %b/%b expected 1/1", stall, bubble);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL loaduse_release: got %b expected 0", stall);
        end
        n_checks++;
        if (stall_cnt !== 16'(c0 + 1) || stall_cnt !== 16'(m_cnt)) begin
            n_fail++; $display("FAIL loaduse_count: got %0d expected %0d", stall_cnt, c0 + 1);
        end
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (pending[6] !== 1'b1 || pending !== m_pending()) begin
            n_fail++; $display("FAIL loaduse_add_issued: got %h expected %h", pending, m_pending());
        end
        step();
    endtask

    task automatic test_r0();
        int unsigned c0;
        drain();
        c0 = m_cnt;
        set_id(1, 1, 1, 0, 0, 0, 1, 1, 0);       // lw r0
        step();
        set_id(1, 0, 1, 0, 1, 6, 0, 0, 0);       // reads r0, writes nothing
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (stall !== 1'b0 || pending !== 32'h0) begin
                n_fail++; $display("FAIL r0 cyc%0d: got stall=%b pending=%h expected 0/0", k, stall, pending);
            end
            step();
            set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        n_checks++;
        if (stall_cnt !== 16'(c0)) begin
            n_fail++; $display("FAIL r0_count: got %0d expected %0d", stall_cnt, c0);
        end
    endtask

    task automatic test_flush();
        int unsigned c0;
        drain();
        c0 = m_cnt;
        set_id(1, 1, 1, 0, 0, 5, 1, 1, 0);       // lw r5
        step();
        set_id(1, 5, 1, 7, 1, 6, 1, 0, 1);       // dependent add, flushed
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall: got %b/%b expected 0/0", stall, bubble);
        end
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (pending[6] !== 1'b0 || pending !== m_pending()) begin
                n_fail++; $display("FAIL flush_pending cyc%0d: got %h expected %h", k, pending, m_pending());
            end
            step();
        end
        n_checks++;
        if (stall_cnt !== 16'(c0)) begin
            n_fail++; $display("FAIL flush_count: got %0d expected %0d", stall_cnt, c0);
        end
    endtask

    task automatic test_triple_writer();
        drain();
        // writers to r9 issue in cycles 0..3; the fourth lands as the first retires
        for (int k = 0; k <= 8; k++) begin
            if (k <= 3) set_id(1, 0, 0, 0, 0, 9, 1, 0, 0);
            else        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            n_checks++;
            if (pending[9] !== ((k >= 1 && k <= 6) ? 1'b1 : 1'b0) || pending !== m_pending()) begin
                n_fail++;
                $display("FAIL triple_r9 cyc%0d: got %h expected %h", k, pending, m_pending());
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int unsigned c0;
        bit exp_s [5] = '{0, 1, 0, 1, 0};
        drain();
        c0 = m_cnt;
        for (int k = 0; k < 5; k++) begin
            case (k)
                0:       set_id(1, 0, 0, 0, 0, 1, 1, 1, 0);  // lw r1
                1, 2:    set_id(1, 1, 1, 0, 0, 2, 1, 1, 0);  // lw r2,0(r1)
                default: set_id(1, 2, 1, 2, 1, 3, 1, 0, 0);  // add r3,r2,r2
            endcase
            @(negedge clk);
            n_checks++;
            if (stall !== exp_s[k]) begin
                n_fail++; $display("FAIL b2b_stall cyc%0d: got %b expected %b", k, stall, exp_s[k]);
            end
            step();
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (stall_cnt !== 16'(c0 + 2)) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected %0d", stall_cnt, c0 + 2);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(199) == 0);
            set_id(($urandom_range(9) < 8), 5'($urandom_range(3)), 1'($urandom_range(1)),
                   5'($urandom_range(3)), 1'($urandom_range(1)), 5'($urandom_range(3)),
                   1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(9) == 0));
            @(negedge clk);
            n_checks++;
            if (stall !== m_stall() || bubble !== m_stall()) begin
                n_fail++;
                $display("FAIL rand_stall cyc%0d: got %b/%b expected %b", k, stall, bubble, m_stall());
            end
            n_checks++;
            if (pending !== m_pending()) begin
                n_fail++; $display("FAIL rand_pending cyc%0d: got %h expected %h", k, pending, m_pending());
            end
            n_checks++;
            if (stall_cnt !== 16'(m_cnt) || stall_cnt_s !== SmallW'(m_cnt_s)) begin
                n_fail++;
                $display("FAIL rand_count cyc%0d: got %0d/%0d expected %0d/%0d",
                         k, stall_cnt, stall_cnt_s, m_cnt, m_cnt_s);
            end
            step();
        end
        rst = 1'b0;
    endtask

    task automatic test_saturation_and_reset();
        bit found = 1'b0;
        drain();
        set_id(1, 5, 1, 0, 0, 5, 1, 1, 0);       // lw r5,0(r5): stalls on itself every other cycle
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            n_checks++;
            if (stall_cnt_s !== SmallW'(m_cnt_s) || stall_cnt !== 16'(m_cnt)) begin
                n_fail++;
                $display("FAIL sat_count cyc%0d: got %0d/%0d expected %0d/%0d",
                         k, stall_cnt_s, stall_cnt, m_cnt_s, m_cnt);
            end
            step();
        end
        n_checks++;
        if (stall_cnt_s !== {SmallW{1'b1}}) begin
            n_fail++; $display("FAIL sat_hold: got %0d expected %0d", stall_cnt_s, (1 << SmallW) - 1);
        end
        for (int k = 0; k < 4 && !found; k++) begin
            @(negedge clk);
            if (stall === 1'b1) found = 1'b1;
            else step();
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL midstall_wait: got no stall expected stall within 4 cycles");
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || bubble !== 1'b0 || pending !== 32'h0) begin
            n_fail++;
            $display("FAIL midstall_reset: got stall=%b bubble=%b pending=%h expected 0", stall, bubble, pending);
        end
        n_checks++;
        if (stall_cnt !== 16'h0 || stall_cnt_s !== '0) begin
            n_fail++; $display("FAIL midstall_count: got %0d/%0d expected 0", stall_cnt, stall_cnt_s);
        end
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (pending !== 32'h20) begin
            n_fail++; $display("FAIL midstall_reissue: got %h expected %h", pending, 32'h20);
        end
        step();
    endtask

    initial begin
        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        test_reset();
        test_alu_writer();
        test_load_use();
        test_r0();
        test_flush();
        test_triple_writer();
        test_back_to_back();
        test_random();
        test_saturation_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
